// File: rtl/serial_word_complementer.sv
// serial_word_complementer: framed LSB-first serial pass / 1's / 2's complementer with overflow flag
module serial_word_complementer #(
    parameter int W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_bit,
    input  logic       in_first,
    input  logic [1:0] mode,
    output logic       out_valid,
    output logic       out_bit,
    output logic       out_first,
    output logic       out_last,
    output logic       ovf,
    output logic       frame_err,
    output logic       busy
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t        state_q;
    logic [CW-1:0] count_q;
    logic          carry_q;
    logic          zeros_q;
    logic [1:0]    mode_q;

    logic          accept;
    logic          start;
    logic [CW-1:0] idx;
    logic [1:0]    m;
    logic          c;
    logic          z;
    logic          last;
    logic          twos;
    logic          r;
    logic          carry_d;
    logic          zeros_d;
    logic          ovf_d;

    // An in_first while ACTIVE restarts the word in place, so every per-word term switches on start.
    assign accept  = in_valid && (in_first || state_q == ACTIVE);
    assign start   = accept && in_first;
    assign idx     = start ? '0 : count_q;
    assign m       = start ? mode : mode_q;
    assign c       = start ? 1'b1 : carry_q;
    assign z       = start ? 1'b1 : zeros_q;
    assign last    = idx == LAST;
    assign twos    = m == 2'b10;
    assign r       = twos ? (~in_bit ^ c) : (m == 2'b01) ? ~in_bit : in_bit;
    assign carry_d = ~in_bit & c;
    assign zeros_d = z & (last | ~in_bit);
    assign ovf_d   = last & twos & z & in_bit;
    assign busy    = state_q == ACTIVE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            carry_q   <= 1'b0;
            zeros_q   <= 1'b0;
            mode_q    <= 2'b00;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            ovf       <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            out_valid <= accept;
            out_bit   <= accept & r;
            out_first <= start;
            out_last  <= accept & last;
            ovf       <= accept & ovf_d;
            frame_err <= start && state_q == ACTIVE;
            if (accept) begin
                mode_q  <= m;
                carry_q <= carry_d;
                zeros_q <= zeros_d;
                count_q <= last ? '0 : idx + CW'(1);
                state_q <= last ? IDLE : ACTIVE;
            end
        end
    end
endmodule

// File: tb/tb_serial_word_complementer.sv
// tb_serial_word_complementer: directed and random checks against a word-arithmetic reference model
module tb_serial_word_complementer;
    localparam int W = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       in_first = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       out_valid, out_bit, out_first, out_last, ovf, frame_err, busy;

    serial_word_complementer #(.W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_first(in_first),
        .mode(mode), .out_valid(out_valid), .out_bit(out_bit), .out_first(out_first),
        .out_last(out_last), .ovf(ovf), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    bit         act = 0;
    int         idx = 0;
    int         mm = 0;
    int         val = 0;
    logic [6:0] exp_v = '0;
    wire  [6:0] got_v = {out_valid, out_bit, out_first, out_last, ovf, frame_err, busy};

    // Reference: result bit i is bit i of the op applied to the word prefix bits 0..i.
    task automatic drive(input logic v, input logic b, input logic f, input logic [1:0] md);
        int pv, res;
        logic ev, eb, ef, el, eo, ee;
        {ev, eb, ef, el, eo, ee} = '0;
        in_valid = v; in_bit = b; in_first = f; mode = md;
        if (v && (f || act)) begin
            ee = f && act;
            if (f) begin act = 1; idx = 0; mm = int'(md); val = 0; end
            val = val | (int'(b) << idx);
            pv  = val;
            res = (mm == 1) ? ~pv : (mm == 2) ? -pv : pv;
            eb  = res[idx];
            ef  = idx == 0;
            el  = idx == W - 1;
            eo  = el && mm == 2 && pv == (1 << (W - 1));
            ev  = 1;
            if (el) act = 0; else idx++;
        end
        exp_v = {ev, eb, ef, el, eo, ee, act};
        @(posedge clk); #1;
    endtask

    task automatic apply_rst();
        rst = 1; in_valid = 0; in_first = 0;
        @(posedge clk); #1;
        rst = 0; act = 0; exp_v = '0;
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 1; in_first = 1; in_bit = 1; mode = 2'b10;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (got_v !== 7'b0) begin errors++; $display("FAIL reset outputs got %b want 0000000", got_v); end
        rst = 0; in_valid = 0; in_first = 0; act = 0;
    endtask

    task automatic test_twos();
        logic [3:0] bits = 4'b0110, w = '0;
        int nb = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1, bits[i], i == 0, 2'b10);
            checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL twos bit%0d got %b want %b", i, got_v, exp_v); end
            w[i] = out_bit;
            nb += int'(busy);
        end
        checks++;
        if (w !== 4'b1010) begin errors++; $display("FAIL twos word got %b want 1010", w); end
        checks++;
        if (nb != 3) begin errors++; $display("FAIL twos busy cycles got %0d want 3", nb); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bits = 8'b0101_0011, w = '0;
        for (int i = 0; i < 8; i++) begin
            drive(1, bits[i], i % 4 == 0, i < 4 ? 2'b01 : 2'b00);
            checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL b2b bit%0d got %b want %b", i, got_v, exp_v); end
            if (i == 4) begin
                checks++;
                if (out_first !== 1'b1) begin errors++; $display("FAIL b2b second first got %b want 1", out_first); end
            end
            w[i] = out_bit;
        end
        checks++;
        if (w !== 8'b0101_1100) begin errors++; $display("FAIL b2b words got %b want 01011100", w); end
    endtask

    task automatic test_ovf();
        logic [7:0] bits = 8'b0000_1000, w = '0;
        for (int i = 0; i < 8; i++) begin
            drive(1, bits[i], i % 4 == 0, 2'b10);
            checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL ovf bit%0d got %b want %b", i, got_v, exp_v); end
            if (i == 3 || i == 7) begin
                checks++;
                if ({out_last, ovf} !== {1'b1, i == 3}) begin
                    errors++; $display("FAIL ovf flag word%0d got %b%b want 1%b", i / 4, out_last, ovf, i == 3);
                end
            end
            w[i] = out_bit;
        end
        checks++;
        if (w !== 8'b0000_1000) begin errors++; $display("FAIL ovf words got %b want 00001000", w); end
    endtask

    task automatic test_gap();
        logic [3:0] bits = 4'b0110, w = '0;
        int k = 0;
        for (int i = 0; i < 7; i++) begin
            if (i >= 2 && i <= 4) drive(0, 1, 1, 2'b00);
            else begin drive(1, bits[k], k == 0, 2'b10); w[k] = out_bit; k++; end
            checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL gap step%0d got %b want %b", i, got_v, exp_v); end
            if (i >= 2 && i <= 4) begin
                checks++;
                if (out_valid !== 1'b0) begin errors++; $display("FAIL gap valid got %b want 0", out_valid); end
            end
        end
        checks++;
        if (w !== 4'b1010) begin errors++; $display("FAIL gap word got %b want 1010", w); end
    endtask

    task automatic test_early_first();
        logic [3:0] bits = 4'b1101, w = '0;
        int nl = 0;
        drive(1, 0, 1, 2'b10);
        nl += int'(out_last);
        drive(1, 1, 0, 2'b10);
        nl += int'(out_last);
        for (int i = 0; i < 4; i++) begin
            drive(1, bits[i], i == 0, 2'b00);
            checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL early bit%0d got %b want %b", i, got_v, exp_v); end
            checks++;
            if (frame_err !== (i == 0)) begin errors++; $display("FAIL early frame_err bit%0d got %b want %b", i, frame_err, i == 0); end
            w[i] = out_bit;
            nl += int'(out_last);
        end
        checks++;
        if (w !== 4'b1101 || nl != 1) begin errors++; $display("FAIL early word got %b/%0d lasts want 1101/1", w, nl); end
    endtask

    task automatic test_rst_mid();
        drive(1, 1, 1, 2'b10);
        drive(1, 0, 0, 2'b10);
        rst = 1; in_valid = 1; in_bit = 1; in_first = 0;
        @(posedge clk); #1;
        rst = 0; act = 0;
        checks++;
        if (got_v !== 7'b0) begin errors++; $display("FAIL rst_mid outputs got %b want 0000000", got_v); end
        drive(1, 1, 0, 2'b10);
        checks++;
        if (out_valid !== 1'b0 || got_v !== exp_v) begin errors++; $display("FAIL rst_mid drop got %b want %b", got_v, exp_v); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 5) == 0, 2'($urandom));
            checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL random step%0d got %b want %b", i, got_v, exp_v); end
        end
    endtask

    initial begin
        test_reset();
        test_twos();
        test_back_to_back();
        test_ovf();
        test_gap();
        test_early_first();
        test_rst_mid();
        apply_rst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_word_complementer.md
Name: serial_word_complementer

Overview:
- Parametrised, framed successor to the single-bit serial 2's complementer.
- Accepts an LSB-first serial stream organised into W-bit words with a valid/first-bit framing.
- Applies a per-word selectable operation (pass, 1's complement, 2's complement) and emits a registered serial result with frame markers and an overflow flag.
- Sits between a serial shift-register source and serial adder/accumulator stages in the Chapter 6 serial datapath.

Parameters:
- W, 8, word length in bits (W >= 2); bit counter is clog2(W) bits wide.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_bit/in_first are meaningful this cycle
- in_bit  input  1  serial data bit, LSB first
- in_first  input  1  marks the LSB (bit 0) of a new word; qualified by in_valid
- mode  input  2  00 pass, 01 1's complement, 10 2's complement, 11 treated as pass; sampled only on an accepted first bit
- out_valid  output  1  out_bit is valid this cycle
- out_bit  output  1  serial result bit, LSB first
- out_first  output  1  out_bit is bit 0 of a result word
- out_last  output  1  out_bit is bit W-1 of a result word
- ovf  output  1  with out_last: 2's-complement mode and input word was 1 followed by W-1 zeros (most negative value)
- frame_err  output  1  one-cycle pulse: a word was aborted by an early in_first
- busy  output  1  a word is in progress (bits 1..W-1 still expected)

Behaviour:
- Reset (rst high at a clk edge) clears: out_valid, out_bit, out_first, out_last, ovf, frame_err, busy, bit counter, carry, zero-tracking flag and held mode. rst overrides all other inputs, including mid-word; the partial word is discarded with no frame_err.
- Reset values: all outputs 0.
- States: IDLE (busy=0) and ACTIVE (busy=1).
- Accepted bit: in_valid=1 and either (IDLE and in_first=1) or ACTIVE.
- in_valid=0: no state change; out_valid=0 next cycle. Gaps of any length inside a word are legal.
- IDLE with in_valid=1 and in_first=0: bit dropped, no output.
- Word start (accepted first bit):
  - Latch mode into held_mode; count <= 1; carry <= 1; zeros <= 1.
  - Go to ACTIVE. If W bits are completed by this bit (not possible, W >= 2), stay IDLE.
- Per accepted bit b at index i (0 for the first bit, else count), with effective mode m (the new mode for i=0, else held_mode):
  - pass: r = b
  - 1's: r = ~b
  - 2's: r = ~b XOR c, c_next = ~b AND c, where c is 1 for i=0, else the carry register. This is equivalent to copying bits through the first 1 and inverting the bits after it.
  - zeros_next = (i=0 ? 1 : zeros) AND (i<W-1 ? ~b : 1). This tracks "all of bits 0..W-2 were zero".
- Output timing (registered, latency exactly 1 cycle from the accepted bit):
  - out_valid=1, out_bit=r, out_first=(i==0), out_last=(i==W-1).
  - ovf = out_last AND m==2's AND zeros(bits 0..W-2) AND b==1.
- End of word: at i==W-1, count <= 0 and state goes to IDLE. The next word needs in_first; back-to-back words with no idle cycle are legal.
- Early first bit: ACTIVE and accepted bit with in_first=1 and count != 0:
  - frame_err=1 for the next cycle.
  - The current word is abandoned (no out_last for it).
  - The bit is processed as bit 0 of a new word in the same cycle, with the new mode sampled.
- Carry out of 2's complement of zero (0 -> 0) is not overflow; ovf stays 0.
- mode changes while ACTIVE are ignored until the next word start.

Test Plan:
- W=4, reset then 2's mode, word 0110 (LSB-first bits 0,1,1,0), no gaps -> out bits 0,1,0,1 (=1010); out_first on cycle 1, out_last on cycle 4; ovf=0; busy high for 3 cycles.
- W=4, 1's mode then pass mode back-to-back: 0011 then 0101 -> outputs 1100 then 0101; the second word's out_first follows the first word's out_last with no gap.
- W=4, 2's mode, input 1000 (bits 0,0,0,1) -> output 1000; ovf=1 coincident with out_last. Input 0000 -> output 0000, ovf=0.
- W=4, 2's mode with in_valid low for 3 cycles between bits 1 and 2 -> same result as gapless; out_valid=0 during the gap; carry is preserved.
- W=4, start word, after 2 bits assert in_first with mode=pass -> frame_err pulse 1 cycle later; no out_last for the aborted word; the new word is passed through unchanged.
- rst asserted after bit 2 of a 2's-mode word -> all outputs 0 next cycle, busy=0. A following in_valid bit without in_first is dropped (out_valid stays 0).
